// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for a RegisterFile write port: per-requester FIFOs,
// round-robin single-pop per cycle, registered write drive and read-hazard snoop.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  input  logic [4:0]  Read_register1,
  input  logic [4:0]  Read_register2,
  output logic        Read_pending1,
  output logic        Read_pending2
);

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] q_addr [2][FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [CNT_W-1:0]  count  [2];

  logic [ADDR_W-1:0] in_addr_p0 [2];
  logic [DATA_W-1:0] in_data_p0 [2];
  logic [1:0]        vld_p0;
  logic [1:0]        ready_p0;
  logic [1:0]        push_p0;
  logic [1:0]        nonempty_p0;
  logic [1:0]        gnt_p0;
  logic              last_gnt;
  logic              sel_p0;
  logic [ADDR_W-1:0] head_addr_p0;
  logic [DATA_W-1:0] head_data_p0;

  logic [PTR_W-1:0]  offs;
  logic              hit1;
  logic              hit2;

  assign vld_p0        = {req1_valid, req0_valid};
  assign in_addr_p0[0] = req0_addr;
  assign in_addr_p0[1] = req1_addr;
  assign in_data_p0[0] = req0_data;
  assign in_data_p0[1] = req1_data;

  // Ready comes purely from registered occupancy, so a full queue stalls one
  // cycle even if its head is popped on the same edge.
  always_comb begin
    ready_p0    = '0;
    nonempty_p0 = '0;
    for (int r = 0; r < 2; r++) begin
      ready_p0[r]    = (count[r] != CNT_W'(FIFO_DEPTH));
      nonempty_p0[r] = (count[r] != '0);
    end
  end

  assign push_p0    = vld_p0 & ready_p0;
  assign req0_ready = ready_p0[0];
  assign req1_ready = ready_p0[1];

  // Round-robin: on contention, the requester not served last wins.
  assign gnt_p0[0] = nonempty_p0[0] & (~nonempty_p0[1] | last_gnt);
  assign gnt_p0[1] = nonempty_p0[1] & (~nonempty_p0[0] | ~last_gnt);
  assign sel_p0    = gnt_p0[1];

  assign head_addr_p0 = q_addr[sel_p0][rd_ptr[sel_p0]];
  assign head_data_p0 = q_data[sel_p0][rd_ptr[sel_p0]];

  // ---- stage p0: queue storage and bookkeeping ----
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push_p0[r]) begin
        q_addr[r][wr_ptr[r]] <= in_addr_p0[r];
        q_data[r][wr_ptr[r]] <= in_data_p0[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        wr_ptr[r] <= '0;
        rd_ptr[r] <= '0;
        count[r]  <= '0;
      end
      last_gnt <= 1'b1;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push_p0[r]) wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
        if (gnt_p0[r])  rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
        case ({push_p0[r], gnt_p0[r]})
          2'b10:   count[r] <= count[r] + CNT_W'(1);
          2'b01:   count[r] <= count[r] - CNT_W'(1);
          default: count[r] <= count[r];
        endcase
      end
      if (|gnt_p0) last_gnt <= sel_p0;
    end
  end

  // ---- stage p1: registered RegisterFile write drive ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else if (|gnt_p0) begin
      RegWrite       <= (head_addr_p0 != '0);
      Write_register <= head_addr_p0;
      Write_data     <= head_data_p0;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Snoop every occupied queue slot plus the write currently on the port.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    offs = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        offs = PTR_W'(i) - rd_ptr[r];
        if (CNT_W'(offs) < count[r]) begin
          if (q_addr[r][i] == Read_register1) hit1 = 1'b1;
          if (q_addr[r][i] == Read_register2) hit2 = 1'b1;
        end
      end
    end
    if (RegWrite && (Write_register == Read_register1)) hit1 = 1'b1;
    if (RegWrite && (Write_register == Read_register2)) hit2 = 1'b1;
    Read_pending1 = hit1 && (Read_register1 != '0);
    Read_pending2 = hit2 && (Read_register2 != '0);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: cycle table plus back-pressure,
// ordering scoreboard and mid-queue reset sequences.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [4:0]  Read_register1, Read_register2;
  logic        Read_pending1, Read_pending2;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .Read_register1(Read_register1), .Read_register2(Read_register2),
    .Read_pending1(Read_pending1), .Read_pending2(Read_pending2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic [4:0] a0; logic [31:0] d0;
    logic v1; logic [4:0] a1; logic [31:0] d1;
    logic [4:0] rr1; logic [4:0] rr2;
    logic rdy0; logic rdy1; logic we; logic chk_w;
    logic [4:0] wr; logic [31:0] wd;
    logic p1; logic p2;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] rr1, input logic [4:0] rr2,
                              input logic we, input logic chk_w, input logic [4:0] wr,
                              input logic [31:0] wd, input logic p1, input logic p2);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.rr1 = rr1; v.rr2 = rr2; v.rdy0 = 1'b1; v.rdy1 = 1'b1;
    v.we = we; v.chk_w = chk_w; v.wr = wr; v.wd = wd; v.p1 = p1; v.p2 = p2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  logic [36:0] sb0 [$];
  logic [36:0] sb1 [$];
  logic [36:0] got;
  logic        acc0, acc1;
  int          sent0, sent1, issued, cyc;

  initial begin
    reset = 1'b1;
    idle_inputs();
    Read_register1 = 5'd0;
    Read_register2 = 5'd0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg", 32'(Write_register), 32'd0);
    chk("rst_wdata", Write_data, 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    chk("rst_pend1", 32'(Read_pending1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contention/alternation, single write, register 0, snoop
    vecs[0]  = mk(1,10,32'hA,1,15,32'hF, 10,15, 0,1, 0,32'h0,        0,0);
    vecs[1]  = mk(0,0,0,0,0,0,          10,15, 0,0, 0,0,             1,1);
    vecs[2]  = mk(1,10,32'hA,1,15,32'hF, 10,15, 1,1, 10,32'hA,        1,1);
    vecs[3]  = mk(0,0,0,0,0,0,          10,15, 1,1, 15,32'hF,        1,1);
    vecs[4]  = mk(0,0,0,0,0,0,          10,15, 1,1, 10,32'hA,        1,1);
    vecs[5]  = mk(0,0,0,0,0,0,          10,15, 1,1, 15,32'hF,        0,1);
    vecs[6]  = mk(1,5,32'hDEADBEEF,0,0,0, 5,15, 0,1, 15,32'hF,        0,0);
    vecs[7]  = mk(0,0,0,0,0,0,           5,0,  0,0, 0,0,             1,0);
    vecs[8]  = mk(0,0,0,0,0,0,           5,0,  1,1, 5,32'hDEADBEEF,  1,0);
    vecs[9]  = mk(1,0,32'h1234,0,0,0,    0,0,  0,0, 0,0,             0,0);
    vecs[10] = mk(0,0,0,0,0,0,           0,0,  0,0, 0,0,             0,0);
    vecs[11] = mk(0,0,0,0,0,0,           0,0,  0,1, 0,32'h1234,      0,0);
    vecs[12] = mk(0,0,0,1,20,32'h55,     20,15, 0,0, 0,0,            0,0);
    vecs[13] = mk(0,0,0,0,0,0,           20,15, 0,0, 0,0,            1,0);
    vecs[14] = mk(0,0,0,0,0,0,           20,15, 1,1, 20,32'h55,      1,0);
    vecs[15] = mk(0,0,0,0,0,0,           20,15, 0,1, 20,32'h55,      0,0);

    for (int k = 0; k < 16; k++) begin
      req0_valid = vecs[k].v0; req0_addr = vecs[k].a0; req0_data = vecs[k].d0;
      req1_valid = vecs[k].v1; req1_addr = vecs[k].a1; req1_data = vecs[k].d1;
      Read_register1 = vecs[k].rr1; Read_register2 = vecs[k].rr2;
      #1;
      chk($sformatf("v%0d_ready0", k), 32'(req0_ready), 32'(vecs[k].rdy0));
      chk($sformatf("v%0d_ready1", k), 32'(req1_ready), 32'(vecs[k].rdy1));
      chk($sformatf("v%0d_regwrite", k), 32'(RegWrite), 32'(vecs[k].we));
      if (vecs[k].chk_w) begin
        chk($sformatf("v%0d_wreg", k), 32'(Write_register), 32'(vecs[k].wr));
        chk($sformatf("v%0d_wdata", k), Write_data, vecs[k].wd);
      end
      chk($sformatf("v%0d_pend1", k), 32'(Read_pending1), 32'(vecs[k].p1));
      chk($sformatf("v%0d_pend2", k), 32'(Read_pending2), 32'(vecs[k].p2));
      @(posedge clk); #1;
    end
    idle_inputs();
    Read_register1 = 5'd0;
    Read_register2 = 5'd0;

    // Back-pressure: both requesters stream four entries each
    sent0 = 0; sent1 = 0; issued = 0; cyc = 0;
    while (!(sent0 == 4 && sent1 == 4 && sb0.size() == 0 && sb1.size() == 0) && cyc < 60) begin
      if (RegWrite) begin
        issued++;
        if (Write_register < 5'd16) begin
          if (sb0.size() == 0) chk("bp_unexpected0", 32'(Write_register), 32'd0);
          else begin got = sb0.pop_front(); chk("bp_order0", {Write_register, Write_data[26:0]}, {got[36:32], got[26:0]}); end
        end else begin
          if (sb1.size() == 0) chk("bp_unexpected1", 32'(Write_register), 32'd0);
          else begin got = sb1.pop_front(); chk("bp_order1", {Write_register, Write_data[26:0]}, {got[36:32], got[26:0]}); end
        end
      end
      req0_valid = (sent0 < 4); req0_addr = 5'(1 + sent0);  req0_data = 32'h1000 + 32'(sent0);
      req1_valid = (sent1 < 4); req1_addr = 5'(17 + sent1); req1_data = 32'h2000 + 32'(sent1);
      #1;
      if (cyc == 2) chk("bp_ready1_full", 32'(req1_ready), 32'd0);
      if (cyc == 3) chk("bp_ready0_full", 32'(req0_ready), 32'd0);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      @(posedge clk);
      if (acc0) begin sb0.push_back({req0_addr, req0_data}); sent0++; end
      if (acc1) begin sb1.push_back({req1_addr, req1_data}); sent1++; end
      #1;
      cyc++;
    end
    chk("bp_drained_in_budget", 32'(cyc < 60), 32'd1);
    chk("bp_issued_count", 32'(issued), 32'd8);
    idle_inputs();
    @(posedge clk); #1;

    // Reset mid-queue: three entries outstanding, one already on the port
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    @(posedge clk); #1;
    req0_addr = 5'd6; req0_data = 32'h66;
    req1_addr = 5'd7; req1_data = 32'h77;
    @(posedge clk); #1;
    idle_inputs();
    Read_register1 = 5'd7;
    Read_register2 = 5'd6;
    #1;
    chk("mr_pre_regwrite", 32'(RegWrite), 32'd1);
    chk("mr_pre_pend1", 32'(Read_pending1), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_regwrite", 32'(RegWrite), 32'd0);
    chk("mr_wreg", 32'(Write_register), 32'd0);
    chk("mr_ready0", 32'(req0_ready), 32'd1);
    chk("mr_ready1", 32'(req1_ready), 32'd1);
    chk("mr_pend1", 32'(Read_pending1), 32'd0);
    chk("mr_pend2", 32'(Read_pending2), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mr_post%0d_regwrite", k), 32'(RegWrite), 32'd0);
      chk($sformatf("mr_post%0d_pend1", k), 32'(Read_pending1), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
